// File: rtl/h264_scan_pkg.sv
// Shared definitions for the 4x4-block / 16x16-macroblock scan controllers:
// FSM state encoding, geometry constants and the registered output bundle.
package h264_scan_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ISSUE = 3'd2,
    STEP1 = 3'd3,
    STEP2 = 3'd4,
    FIN   = 3'd5
  } scan_state_t;

  // Which counter move follows the block just transferred.
  typedef enum logic [1:0] {
    STP_COL   = 2'd0,
    STP_ROW   = 2'd1,
    STP_MB    = 2'd2,
    STP_MBROW = 2'd3
  } step_kind_t;

  localparam int unsigned BLK_SIZE         = 4;
  localparam int unsigned MB_SIZE          = 16;
  localparam int unsigned BLKS_PER_MB_SIDE = 4;
  localparam logic [1:0]  SUB_LAST         = 2'(BLKS_PER_MB_SIDE - 1);

  typedef struct packed {
    logic blk_valid;
    logic en_x;
    logic incr_x;
    logic dcr_x;
    logic clr_x;
    logic en_y;
    logic incr_y;
    logic dcr_y;
    logic clr_y;
    logic mb_first;
    logic mb_last;
    logic busy;
    logic done;
  } scan_out_t;

  function automatic logic [3:0] blk_index(input logic [1:0] col, input logic [1:0] row);
    return {row, col};
  endfunction

endpackage

// File: rtl/mb_scan_ctrl.sv
// Walks a frame in 4x4 blocks (raster inside each macroblock, macroblocks raster
// across the frame) by pulsing commands to external x/y position counters.
//
// state | meaning
// IDLE  | waiting for start with non-zero frame dimensions
// CLR   | clearing external x/y counters and internal indices
// ISSUE | presenting a block, waiting for blk_ready
// STEP1 | first counter move after a transfer
// STEP2 | second counter move (row wrap or macroblock advance)
// FIN   | final counter clear and done pulse
module mb_scan_ctrl
  import h264_scan_pkg::*;
#(
  parameter int MB_DIM_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [MB_DIM_W-1:0] frame_w_mb,
  input  logic [MB_DIM_W-1:0] frame_h_mb,
  output logic                blk_valid,
  input  logic                blk_ready,
  output logic                en_x,
  output logic                incr_x,
  output logic                dcr_x,
  output logic                clr_x,
  output logic                en_y,
  output logic                incr_y,
  output logic                dcr_y,
  output logic                clr_y,
  output logic                mb_first,
  output logic                mb_last,
  output logic                busy,
  output logic                done
);

  scan_state_t         state_q, state_d;
  step_kind_t          kind_q, kind_d;
  logic [1:0]          col_q, col_d;
  logic [1:0]          row_q, row_d;
  logic [MB_DIM_W-1:0] mb_col_q, mb_col_d;
  logic [MB_DIM_W-1:0] mb_row_q, mb_row_d;
  logic [MB_DIM_W-1:0] w_q, w_d;
  logic [MB_DIM_W-1:0] h_q, h_d;
  scan_out_t           out_q, out_d;

  logic xfer;
  logic mb_col_last;
  logic mb_row_last;

  assign xfer        = out_q.blk_valid & blk_ready;
  assign mb_col_last = (mb_col_q == w_q - MB_DIM_W'(1));
  assign mb_row_last = (mb_row_q == h_q - MB_DIM_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      kind_q   <= STP_COL;
      col_q    <= '0;
      row_q    <= '0;
      mb_col_q <= '0;
      mb_row_q <= '0;
      w_q      <= '0;
      h_q      <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      col_q    <= col_d;
      row_q    <= row_d;
      mb_col_q <= mb_col_d;
      mb_row_q <= mb_row_d;
      w_q      <= w_d;
      h_q      <= h_d;
      out_q    <= out_d;
    end
  end

  // Indices advance at the transfer; the step kind remembers which counter
  // moves the following STEP states must issue.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    col_d    = col_q;
    row_d    = row_q;
    mb_col_d = mb_col_q;
    mb_row_d = mb_row_q;
    w_d      = w_q;
    h_d      = h_q;
    case (state_q)
      IDLE: begin
        if (start && (frame_w_mb != '0) && (frame_h_mb != '0)) begin
          state_d = CLR;
          w_d     = frame_w_mb;
          h_d     = frame_h_mb;
        end
      end
      CLR: begin
        state_d  = ISSUE;
        col_d    = '0;
        row_d    = '0;
        mb_col_d = '0;
        mb_row_d = '0;
      end
      ISSUE: begin
        if (xfer) begin
          if (col_q != SUB_LAST) begin
            state_d = STEP1;
            kind_d  = STP_COL;
            col_d   = col_q + 2'd1;
          end else if (row_q != SUB_LAST) begin
            state_d = STEP1;
            kind_d  = STP_ROW;
            col_d   = '0;
            row_d   = row_q + 2'd1;
          end else if (!mb_col_last) begin
            state_d  = STEP1;
            kind_d   = STP_MB;
            col_d    = '0;
            row_d    = '0;
            mb_col_d = mb_col_q + MB_DIM_W'(1);
          end else if (!mb_row_last) begin
            state_d  = STEP1;
            kind_d   = STP_MBROW;
            col_d    = '0;
            row_d    = '0;
            mb_col_d = '0;
            mb_row_d = mb_row_q + MB_DIM_W'(1);
          end else begin
            state_d = FIN;
          end
        end
      end
      STEP1: begin
        if ((kind_q == STP_ROW) || (kind_q == STP_MB)) begin
          state_d = STEP2;
        end else begin
          state_d = ISSUE;
        end
      end
      STEP2: state_d = ISSUE;
      FIN: begin
        state_d  = IDLE;
        col_d    = '0;
        row_d    = '0;
        mb_col_d = '0;
        mb_row_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that, once registered, they
  // line up with the state they belong to.
  always_comb begin
    out_d      = '0;
    out_d.busy = (state_d != IDLE);
    case (state_d)
      CLR: begin
        out_d.clr_x = 1'b1;
        out_d.clr_y = 1'b1;
      end
      ISSUE: begin
        out_d.blk_valid = 1'b1;
        out_d.mb_first  = (blk_index(col_d, row_d) == 4'd0);
        out_d.mb_last   = (blk_index(col_d, row_d) == 4'd15);
      end
      STEP1: begin
        case (kind_d)
          STP_COL: out_d.en_x = 1'b1;
          STP_ROW, STP_MB: begin
            out_d.en_x = 1'b1;
            out_d.en_y = 1'b1;
          end
          STP_MBROW: begin
            out_d.clr_x = 1'b1;
            out_d.en_y  = 1'b1;
          end
          default: out_d.en_x = 1'b0;
        endcase
      end
      STEP2: begin
        if (kind_d == STP_ROW) begin
          out_d.dcr_x = 1'b1;
        end else begin
          out_d.dcr_y = 1'b1;
        end
      end
      FIN: begin
        out_d.clr_x = 1'b1;
        out_d.clr_y = 1'b1;
        out_d.done  = 1'b1;
      end
      default: out_d.busy = out_d.busy;
    endcase
  end

  assign blk_valid = out_q.blk_valid;
  assign en_x      = out_q.en_x;
  assign incr_x    = out_q.incr_x;
  assign dcr_x     = out_q.dcr_x;
  assign clr_x     = out_q.clr_x;
  assign en_y      = out_q.en_y;
  assign incr_y    = out_q.incr_y;
  assign dcr_y     = out_q.dcr_y;
  assign clr_y     = out_q.clr_y;
  assign mb_first  = out_q.mb_first;
  assign mb_last   = out_q.mb_last;
  assign busy      = out_q.busy;
  assign done      = out_q.done;

endmodule

// File: tb/tb_mb_scan_ctrl.sv
// Bench for mb_scan_ctrl: models the external x/y counters from the command
// pulses and compares each presented block against an independently built scan list.
module tb_mb_scan_ctrl;
  import h264_scan_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] frame_w_mb;
  logic [W-1:0] frame_h_mb;
  logic         blk_valid;
  logic         blk_ready;
  logic         en_x, incr_x, dcr_x, clr_x;
  logic         en_y, incr_y, dcr_y, clr_y;
  logic         mb_first, mb_last, busy, done;

  always #5 clk = ~clk;

  mb_scan_ctrl #(.MB_DIM_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frame_w_mb(frame_w_mb),
    .frame_h_mb(frame_h_mb),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .en_x      (en_x),
    .incr_x    (incr_x),
    .dcr_x     (dcr_x),
    .clr_x     (clr_x),
    .en_y      (en_y),
    .incr_y    (incr_y),
    .dcr_y     (dcr_y),
    .clr_y     (clr_y),
    .mb_first  (mb_first),
    .mb_last   (mb_last),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    int x;
    int y;
    int first;
    int last;
  } blk_t;

  typedef struct {
    int w;
    int h;
    int stall_pct;
    int stall_at;
    int exp_blocks;
  } vec_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   mx     = 0;
  int   my     = 0;
  blk_t exp_q[$];
  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  function automatic int outs_vec();
    logic [12:0] v;
    v = {blk_valid, en_x, incr_x, dcr_x, clr_x, en_y, incr_y, dcr_y, clr_y,
         mb_first, mb_last, busy, done};
    return int'(v);
  endfunction

  // External counters: applied at the posedge following the sampled pulse.
  task automatic apply_model();
    if (clr_x) mx = 0;
    else if (en_x) mx = mx + int'(BLK_SIZE);
    else if (incr_x) mx = mx + int'(MB_SIZE);
    else if (dcr_x) mx = mx - int'(MB_SIZE);
    if (clr_y) my = 0;
    else if (en_y) my = my + int'(BLK_SIZE);
    else if (incr_y) my = my + int'(MB_SIZE);
    else if (dcr_y) my = my - int'(MB_SIZE);
  endtask

  task automatic build_scan(input int w, input int h);
    blk_t b;
    exp_q.delete();
    for (int mr = 0; mr < h; mr++)
      for (int mc = 0; mc < w; mc++)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            b.x     = 16 * mc + 4 * c;
            b.y     = 16 * mr + 4 * r;
            b.first = (r == 0 && c == 0) ? 1 : 0;
            b.last  = (r == 3 && c == 3) ? 1 : 0;
            exp_q.push_back(b);
          end
  endtask

  task automatic run_frame(input int w, input int h, input int stall_pct,
                           input int stall_at, input int exp_blocks);
    int nblk, ndone, n_xy, n_cy, first_cyc, stall_left;
    bit stall_done, fin, rdy;
    blk_t b;
    nblk = 0; ndone = 0; n_xy = 0; n_cy = 0; first_cyc = -1; stall_left = 0;
    stall_done = 0; fin = 0;
    build_scan(w, h);
    @(negedge clk);
    frame_w_mb = W'(w);
    frame_h_mb = W'(h);
    start      = 1'b1;
    blk_ready  = 1'($urandom_range(1));
    if (exp_blocks == 0) begin
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        start = 1'b0;
        chk("zero_dim_busy", int'(busy), 0);
        chk("zero_dim_valid", int'(blk_valid), 0);
      end
      blk_ready = 1'b0;
      return;
    end
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 0) chk("clr_pulse", int'(clr_x & clr_y & ~blk_valid), 1);
      if (blk_valid && first_cyc < 0) begin
        first_cyc = cyc;
        chk("first_valid_lat", cyc, 1);
      end
      chk("one_cmd_x", int'(en_x) + int'(incr_x) + int'(dcr_x) + int'(clr_x) <= 1 ? 1 : 0, 1);
      chk("one_cmd_y", int'(en_y) + int'(incr_y) + int'(dcr_y) + int'(clr_y) <= 1 ? 1 : 0, 1);
      chk("incr_zero", int'(incr_x | incr_y), 0);
      if (en_x && en_y) n_xy++;
      if (clr_x && en_y) n_cy++;
      if (blk_valid) begin
        chk("cmd_while_valid", int'(en_x | dcr_x | clr_x | en_y | dcr_y | clr_y), 0);
        if (exp_q.size() == 0) chk("extra_block", 1, 0);
        else begin
          chk("blk_x", mx, exp_q[0].x);
          chk("blk_y", my, exp_q[0].y);
          chk("mb_first", int'(mb_first), exp_q[0].first);
          chk("mb_last", int'(mb_last), exp_q[0].last);
        end
      end
      if (stall_left == 0 && !stall_done && blk_valid && nblk == stall_at) begin
        stall_left = 5;
        stall_done = 1;
      end
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
        chk("hold_valid", int'(blk_valid), 1);
      end else begin
        rdy = ($urandom_range(99) >= stall_pct);
      end
      blk_ready = rdy;
      if (blk_valid && rdy) begin
        if (exp_q.size() > 0) b = exp_q.pop_front();
        nblk++;
      end
      if (done) begin
        ndone++;
        fin = 1;
      end else if (busy && $urandom_range(15) == 0) begin
        start      = 1'b1;
        frame_w_mb = W'($urandom_range(0, 5));
        frame_h_mb = W'($urandom_range(0, 5));
      end
      apply_model();
    end
    blk_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("frame_timeout", int'(fin), 1);
    chk("idle_after", int'(busy), 0);
    chk("blocks", nblk, exp_blocks);
    chk("done_once", ndone, 1);
    chk("final_x", mx, 0);
    chk("final_y", my, 0);
    chk("exp_left", exp_q.size(), 0);
    chk("en_xy_count", n_xy, 3 * w * h + (w - 1) * h);
    chk("clrx_eny_count", n_cy, h - 1);
    if (stall_at >= 0) chk("stall_hit", int'(stall_done), 1);
  endtask

  task automatic reset_mid_frame();
    int nblk;
    bit hit;
    nblk = 0; hit = 0;
    @(negedge clk);
    frame_w_mb = W'(2);
    frame_h_mb = W'(2);
    start      = 1'b1;
    blk_ready  = 1'b1;
    for (int cyc = 0; cyc < 500 && !hit; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (blk_valid && nblk == 7) begin
        hit        = 1;
        rst        = 1'b1;
        start      = 1'b1;
        blk_ready  = 1'b1;
      end else if (blk_valid) begin
        nblk++;
      end
      apply_model();
    end
    chk("rst_reached_blk7", int'(hit), 1);
    @(negedge clk);
    chk("rst_mid_outs", outs_vec(), 0);
    rst       = 1'b0;
    start     = 1'b0;
    blk_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_done", int'(done), 0);
      chk("rst_stays_idle", int'(busy), 0);
    end
    blk_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{w: 2, h: 1, stall_pct: 0,  stall_at: -1, exp_blocks: 32};
    vecs[1] = '{w: 1, h: 2, stall_pct: 0,  stall_at: -1, exp_blocks: 32};
    vecs[2] = '{w: 1, h: 1, stall_pct: 0,  stall_at: -1, exp_blocks: 16};
    vecs[3] = '{w: 2, h: 2, stall_pct: 30, stall_at: 3,  exp_blocks: 64};
    vecs[4] = '{w: 3, h: 2, stall_pct: 20, stall_at: 17, exp_blocks: 96};
    vecs[5] = '{w: 0, h: 3, stall_pct: 0,  stall_at: -1, exp_blocks: 0};
    vecs[6] = '{w: 2, h: 0, stall_pct: 0,  stall_at: -1, exp_blocks: 0};

    rst        = 1'b1;
    start      = 1'b0;
    blk_ready  = 1'b0;
    frame_w_mb = '0;
    frame_h_mb = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", outs_vec(), 0);
    start      = 1'b1;
    blk_ready  = 1'b1;
    frame_w_mb = W'(2);
    frame_h_mb = W'(2);
    @(negedge clk);
    chk("reset_over_start", outs_vec(), 0);
    rst       = 1'b0;
    start     = 1'b0;
    blk_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", int'(busy), 0);

    for (int i = 0; i < 7; i++)
      run_frame(vecs[i].w, vecs[i].h, vecs[i].stall_pct, vecs[i].stall_at, vecs[i].exp_blocks);

    reset_mid_frame();
    run_frame(2, 2, 0, -1, 64);

    for (int i = 0; i < 5; i++) begin
      int rw, rh;
      rw = $urandom_range(1, 3);
      rh = $urandom_range(1, 3);
      run_frame(rw, rh, $urandom_range(0, 40), -1, 16 * rw * rh);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mb_scan_ctrl.md
MB_SCAN_CTRL -- requirements
Module: mb_scan_ctrl

Interface
REQ-001 SHALL have parameter MB_DIM_W, default 8: width of the macroblock-count inputs and internal MB indices.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1: begin a frame scan; sampled only in IDLE.
REQ-005 SHALL have port frame_w_mb, input, MB_DIM_W: frame width in macroblocks; latched on accepted start.
REQ-006 SHALL have port frame_h_mb, input, MB_DIM_W: frame height in macroblocks; latched on accepted start.
REQ-007 SHALL have port blk_valid, output, 1: the current 4x4 block at the external (x, y) counters is presented.
REQ-008 SHALL have port blk_ready, input, 1: the consumer accepts the block; transfer = blk_valid & blk_ready.
REQ-009 SHALL have ports en_x, incr_x, dcr_x, clr_x, output, 1 each: x-counter commands (+4, +16, -16, to 0).
REQ-010 SHALL have ports en_y, incr_y, dcr_y, clr_y, output, 1 each: y-counter commands (+4, +16, -16, to 0).
REQ-011 SHALL have ports mb_first, mb_last, output, 1 each: blk_valid block is block 0 / block 15 of its macroblock.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse after the final block of the frame.

Function
REQ-014 SHALL implement states IDLE, CLR, ISSUE, STEP1, STEP2, FIN.
REQ-015 SHALL register every output; command outputs SHALL be one-cycle pulses; at most one command per axis per cycle.
REQ-016 IDLE: start with frame_w_mb != 0 and frame_h_mb != 0 -> CLR; start with a zero dimension SHALL be ignored.
REQ-017 CLR: pulse clr_x and clr_y, clear col, row, mb_col, mb_row -> ISSUE; first blk_valid is 2 cycles after start.
REQ-018 ISSUE: hold blk_valid until transfer; no command SHALL be issued while waiting.
REQ-019 Scan order: 4x4 blocks raster within the MB (col 0..3, then row 0..3); MBs raster within the frame.
REQ-020 After transfer with col<3: STEP1 pulses en_x, col+1 -> ISSUE.
REQ-021 After transfer with col=3, row<3: STEP1 pulses en_x and en_y, then STEP2 pulses dcr_x; col=0, row+1 -> ISSUE.
REQ-022 After the last block of an MB with mb_col<W-1: STEP1 pulses en_x and en_y, then STEP2 pulses dcr_y; mb_col+1 -> ISSUE.
REQ-023 After the last block of an MB with mb_col=W-1, mb_row<H-1: STEP1 pulses clr_x and en_y; mb_col=0, mb_row+1 -> ISSUE.
REQ-024 After the last block of the frame: FIN pulses clr_x, clr_y and done -> IDLE.
REQ-025 incr_x and incr_y SHALL remain 0 in this scan order and are reserved.
REQ-026 Net effect: at every blk_valid, x = 16*mb_col + 4*col and y = 16*mb_row + 4*row.
REQ-027 start while busy SHALL be ignored; frame dimensions SHALL NOT change mid-frame.
REQ-028 blk_ready while blk_valid=0 SHALL have no effect.
REQ-029 W=1 or H=1 SHALL scan correctly; W=H=1 SHALL emit exactly 16 blocks.

Reset
REQ-030 rst SHALL force IDLE, zero all indices and latched dimensions, and drive all outputs 0, including mid-frame; no done SHALL follow.
REQ-031 rst SHALL take priority over start and blk_ready in the same cycle.

Structure
REQ-032 Shared package h264_scan_pkg SHALL hold the state enum, BLK_SIZE=4, MB_SIZE=16, BLKS_PER_MB_SIDE=4.
REQ-033 SHALL be a single module with no sub-modules; the counters are instantiated externally and driven by these ports.

Verification
REQ-034 W=2, H=1, blk_ready=1 -> 32 transfers; x/y models visit (0,0),(4,0)..(12,12),(16,0)..(28,12); done once; final x=y=0.
REQ-035 W=1, H=2 -> after block 15, clr_x+en_y in the same cycle; block 16 at (0,16); 32 blocks total.
REQ-036 blk_ready low for 5 cycles at block 3 -> blk_valid held; no command pulses; scan resumes unchanged.
REQ-037 rst asserted at block 7 of W=H=2 -> next cycle all outputs 0, IDLE; a new start rescans from (0,0).
REQ-038 start with frame_w_mb=0 -> busy stays 0; start pulse while busy -> no effect on sequence or block count.
REQ-039 Every cycle: assert at most one command per axis; mb_first/mb_last match block index 0/15.
